// File: rtl/pool_engine_if.sv
// Stream and control bundle for one pooling lane: start/config, element stream, result.
// Element handshake: a transfer happens on a rising edge where data_valid && data_ready; the source holds data until then.
interface pool_engine_if #(
  parameter int CNT_W = 32
);
  logic             pool_ready;
  logic             mode;
  logic [CNT_W-1:0] op_num;
  logic [15:0]      recip;
  logic [15:0]      data;
  logic             data_valid;
  logic             data_ready;
  logic [15:0]      result;
  logic             pool_valid;
  logic             busy;

  modport master (
    output pool_ready, mode, op_num, recip, data, data_valid,
    input  data_ready, result, pool_valid, busy
  );

  modport slave (
    input  pool_ready, mode, op_num, recip, data, data_valid,
    output data_ready, result, pool_valid, busy
  );
endinterface

// File: rtl/pool_engine.sv
// FP16 pooling lane: MAX in one pass, AVE as a serial accumulate through a fixed-latency
// adder followed by one multiply with the supplied reciprocal.
module pool_engine #(
  parameter int ADD_LAT = 4,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  pool_engine_if.slave pif,
  output logic [2:0]   state_o
);
  typedef enum logic [2:0] {IDLE, LOAD, ADD_WAIT, SCALE, DONE} state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [15:0]      recip_q, recip_d, acc_q, acc_d, max_q, max_d, result_q, result_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [15:0]      add_pipe_q [ADD_LAT];
  logic [15:0]      mul_pipe_q [MUL_LAT];
  logic [ADD_LAT-1:0] add_vld_q;
  logic [MUL_LAT-1:0] mul_vld_q;
  logic             add_nd, mul_nd, xfer;
  logic [15:0]      max_nx;

  // m = hidden.frac[9:0].guard.round.sticky, e = exponent (>=1); round to nearest even.
  function automatic logic [15:0] round_pack(input logic s, input logic [6:0] e, input logic [13:0] m);
    logic [11:0] mt;
    logic [6:0]  ef;
    logic        rnd;
    rnd = m[2] & (m[1] | m[0] | m[3]);
    mt  = {1'b0, m[13:3]} + {11'd0, rnd};
    ef  = e;
    if (mt[11]) begin
      mt = mt >> 1;
      ef = ef + 7'd1;
    end
    if (!mt[10]) ef = 7'd0;
    if (ef >= 7'd31) return {s, 15'h7C00};
    return {s, ef[4:0], mt[9:0]};
  endfunction

  function automatic logic is_nan(input logic [15:0] a);
    return (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [4:0]  ex, ey, d;
    logic [10:0] mx, my;
    logic [13:0] xm, ym, m;
    logic [24:0] t;
    logic [14:0] sum;
    logic [6:0]  e;
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    if (a[14:10] == 5'h1F && b[14:10] == 5'h1F && a[15] != b[15]) return 16'h7E00;
    if (a[14:10] == 5'h1F) return a;
    if (b[14:10] == 5'h1F) return b;
    if (a[14:0] >= b[14:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
    mx = {x[14:10] != 5'd0, x[9:0]};
    my = {y[14:10] != 5'd0, y[9:0]};
    d  = ex - ey;
    xm = {mx, 3'b000};
    t  = {my, 14'd0} >> d;
    ym = (d > 5'd13) ? {13'd0, |my} : {t[24:12], t[11] | (|t[10:0])};
    e  = {2'b00, ex};
    if (x[15] == y[15]) begin
      sum = {1'b0, xm} + {1'b0, ym};
      if (sum[14]) begin
        m = {sum[14:2], sum[1] | sum[0]};
        e = e + 7'd1;
      end else begin
        m = sum[13:0];
      end
    end else begin
      m = xm - ym;
      if (m == 14'd0) return 16'h0000;
      for (int i = 0; i < 13; i++) begin
        if (!m[13] && e > 7'd1) begin
          m = m << 1;
          e = e - 7'd1;
        end
      end
    end
    return round_pack(x[15], e, m);
  endfunction

  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic              s;
    logic [4:0]        ea, eb;
    logic [21:0]       p;
    logic signed [7:0] e;
    s = a[15] ^ b[15];
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    if (a[14:10] == 5'h1F) return (b[14:0] == 15'd0) ? 16'h7E00 : {s, 15'h7C00};
    if (b[14:10] == 5'h1F) return (a[14:0] == 15'd0) ? 16'h7E00 : {s, 15'h7C00};
    if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {s, 15'd0};
    ea = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    eb = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    p  = {11'd0, a[14:10] != 5'd0, a[9:0]} * {11'd0, b[14:10] != 5'd0, b[9:0]};
    e  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd14;
    for (int i = 0; i < 22; i++) begin
      if (!p[21] && e > 8'sd1) begin
        p = p << 1;
        e = e - 8'sd1;
      end
    end
    // Below the normal range: denormalise, keeping shifted-out bits as sticky.
    for (int i = 0; i < 26; i++) begin
      if (e < 8'sd1) begin
        p = {1'b0, p[21:1]} | {21'd0, p[0]};
        e = e + 8'sd1;
      end
    end
    if (e > 8'sd30) return {s, 15'h7C00};
    return round_pack(s, e[6:0], {p[21:11], p[10], p[9], |p[8:0]});
  endfunction

  // Strict sign-magnitude greater-than; a NaN candidate never wins and +0 == -0.
  function automatic logic fp16_gt(input logic [15:0] a, input logic [15:0] b);
    if (is_nan(a)) return 1'b0;
    if (a[14:0] == 15'd0 && b[14:0] == 15'd0) return 1'b0;
    if (a[15] != b[15]) return b[15];
    if (!a[15]) return a[14:0] > b[14:0];
    return a[14:0] < b[14:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    recip_d  = recip_q;
    acc_d    = acc_q;
    max_d    = max_q;
    remain_d = remain_q;
    result_d = result_q;
    add_nd   = 1'b0;
    mul_nd   = 1'b0;
    xfer     = (state_q == LOAD) && pif.data_valid;
    max_nx   = fp16_gt(pif.data, max_q) ? pif.data : max_q;
    case (state_q)
      IDLE: begin
        if (pif.pool_ready) begin
          mode_d   = pif.mode;
          recip_d  = pif.recip;
          remain_d = pif.op_num;
          acc_d    = 16'h0000;
          max_d    = 16'hFC00;
          if (pif.op_num == '0) begin
            result_d = 16'h0000;
            state_d  = DONE;
          end else begin
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          if (remain_q != '0) remain_d = remain_q - 1'b1;
          if (mode_q) begin
            max_d = max_nx;
            if (remain_q <= 1) begin
              result_d = max_nx;
              state_d  = DONE;
            end
          end else begin
            add_nd  = 1'b1;
            state_d = ADD_WAIT;
          end
        end
      end
      ADD_WAIT: begin
        if (add_vld_q[ADD_LAT-1]) begin
          acc_d   = add_pipe_q[ADD_LAT-1];
          state_d = (remain_q != '0) ? LOAD : SCALE;
        end
      end
      SCALE: begin
        // Nothing in flight means this is the entry cycle: issue the single product.
        mul_nd = (mul_vld_q == '0);
        if (mul_vld_q[MUL_LAT-1]) begin
          result_d = mul_pipe_q[MUL_LAT-1];
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      recip_q  <= 16'h0000;
      acc_q    <= 16'h0000;
      max_q    <= 16'h0000;
      remain_q <= '0;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      recip_q  <= recip_d;
      acc_q    <= acc_d;
      max_q    <= max_d;
      remain_q <= remain_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_vld_q <= '0;
      mul_vld_q <= '0;
      for (int i = 0; i < ADD_LAT; i++) add_pipe_q[i] <= 16'h0000;
      for (int i = 0; i < MUL_LAT; i++) mul_pipe_q[i] <= 16'h0000;
    end else begin
      add_vld_q[0]  <= add_nd;
      add_pipe_q[0] <= fp16_add(acc_q, pif.data);
      for (int i = 1; i < ADD_LAT; i++) begin
        add_vld_q[i]  <= add_vld_q[i-1];
        add_pipe_q[i] <= add_pipe_q[i-1];
      end
      mul_vld_q[0]  <= mul_nd;
      mul_pipe_q[0] <= fp16_mul(acc_q, recip_q);
      for (int i = 1; i < MUL_LAT; i++) begin
        mul_vld_q[i]  <= mul_vld_q[i-1];
        mul_pipe_q[i] <= mul_pipe_q[i-1];
      end
    end
  end

  assign pif.data_ready = (state_q == LOAD);
  assign pif.pool_valid = (state_q == DONE);
  assign pif.busy       = (state_q != IDLE);
  assign pif.result     = result_q;
  assign state_o        = state_q;
endmodule
